// File: rtl/pulse_tx.sv
// pulse_tx: test-pulse burst transmitter.
// On an accepted start it drives a burst of num_pulses rectangular pulses on
// DATA_OUT, each pulse_width cycles high separated by gap_width cycles low, then
// strobes done for one cycle. abort cuts the burst short and flags aborted.
//
// Ports:
//   CLK_IN      system clock, rising edge
//   rst         asynchronous active-high reset
//   start       burst request, sampled only in IDLE
//   pulse_width high-phase length in cycles (0 treated as 1)
//   gap_width   low-phase length in cycles (0 treated as 1)
//   num_pulses  pulses per burst (0 gives an empty burst)
//   abort       terminate the running burst
//   DATA_OUT    registered pulse line
//   busy        high while a burst is running (HIGH or LOW)
//   done        one-cycle completion strobe
//   aborted     last burst was aborted; held until the next accepted start
//   pulses_sent completed high phases in the current or last burst
module pulse_tx #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NUM_W = 8
) (
  input  logic             CLK_IN,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] gap_width,
  input  logic [NUM_W-1:0] num_pulses,
  input  logic             abort,
  output logic             DATA_OUT,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [NUM_W-1:0] pulses_sent
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pw;
  logic [CNT_W-1:0] r_gap;
  logic [NUM_W-1:0] r_num;
  logic [NUM_W-1:0] r_sent;
  logic             r_data;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  // Zero widths are promoted to one so every phase lasts at least a cycle.
  logic [CNT_W-1:0] w_pw_eff;
  logic [CNT_W-1:0] w_gap_eff;
  logic [NUM_W-1:0] w_sent_inc;

  assign w_pw_eff   = (pulse_width == '0) ? CNT_W'(1) : pulse_width;
  assign w_gap_eff  = (gap_width   == '0) ? CNT_W'(1) : gap_width;
  assign w_sent_inc = r_sent + NUM_W'(1);

  // Burst FSM; DATA_OUT/busy/done are registered alongside the state they decode.
  always_ff @(posedge CLK_IN or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pw      <= CNT_W'(1);
      r_gap     <= CNT_W'(1);
      r_num     <= '0;
      r_sent    <= '0;
      r_data    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pw      <= w_pw_eff;
            r_gap     <= w_gap_eff;
            r_num     <= num_pulses;
            r_sent    <= '0;
            r_aborted <= 1'b0;
            if (num_pulses != '0) begin
              r_state <= S_HIGH;
              r_cnt   <= w_pw_eff - CNT_W'(1);
              r_data  <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        S_HIGH: begin
          if (abort) begin
            // A pulse cut short is not counted.
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
            r_data    <= 1'b0;
            r_busy    <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_sent <= w_sent_inc;
            r_data <= 1'b0;
            if (w_sent_inc == r_num) begin
              // Last pulse: finish without a trailing gap.
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_LOW;
              r_cnt   <= r_gap - CNT_W'(1);
            end
          end
        end

        S_LOW: begin
          if (abort) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
            r_data    <= 1'b0;
            r_busy    <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= S_HIGH;
            r_cnt   <= r_pw - CNT_W'(1);
            r_data  <= 1'b1;
          end
        end

        S_DONE: begin
          // Start is ignored here; a new burst is taken from the next IDLE cycle.
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_data  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign DATA_OUT    = r_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign pulses_sent = r_sent;

endmodule

// File: tb/tb_pulse_tx.sv
// Directed bench for pulse_tx: per-cycle output traces compared to hand-built patterns.
// Pattern strings list cycles t+1, t+2, ... left to right, where t is the edge that took start.
module tb_pulse_tx;

  logic        CLK_IN = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pulse_width;
  logic [15:0] gap_width;
  logic [7:0]  num_pulses;
  logic        abort;
  logic        DATA_OUT;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  pulses_sent;

  int checks   = 0;
  int failures = 0;

  logic [31:0] cap_data;
  logic [31:0] cap_busy;
  logic [31:0] cap_done;
  logic [31:0] cap_abt;

  pulse_tx #(.CNT_W(16), .NUM_W(8)) dut (
    .CLK_IN      (CLK_IN),
    .rst         (rst),
    .start       (start),
    .pulse_width (pulse_width),
    .gap_width   (gap_width),
    .num_pulses  (num_pulses),
    .abort       (abort),
    .DATA_OUT    (DATA_OUT),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .pulses_sent (pulses_sent)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pattern string -> bit vector, character i maps to bit i (cycle t+1+i).
  function automatic logic [31:0] pat(input string s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[i] = (s[i] == 8'h31);
    return r;
  endfunction

  // Launch a burst and record n cycles of outputs; smask/amask drive start/abort
  // during cycle k (bit k-1), so they are sampled on the edge ending that cycle.
  task automatic run_burst(input logic [15:0] pw, input logic [15:0] gap,
                           input logic [7:0] num, input int n,
                           input logic [31:0] smask, input logic [31:0] amask,
                           input logic [15:0] pw_after);
    @(negedge CLK_IN);
    pulse_width = pw;
    gap_width   = gap;
    num_pulses  = num;
    start       = 1'b1;
    @(posedge CLK_IN);
    #1;
    start       = 1'b0;
    pulse_width = pw_after;
    cap_data = '0;
    cap_busy = '0;
    cap_done = '0;
    cap_abt  = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge CLK_IN);
      cap_data[k-1] = DATA_OUT;
      cap_busy[k-1] = busy;
      cap_done[k-1] = done;
      cap_abt[k-1]  = aborted;
      start = smask[k-1];
      abort = amask[k-1];
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    pulse_width = '0;
    gap_width   = '0;
    num_pulses  = '0;
    repeat (2) @(negedge CLK_IN);
    chk("rst_data",    32'(DATA_OUT),    32'd0);
    chk("rst_busy",    32'(busy),        32'd0);
    chk("rst_done",    32'(done),        32'd0);
    chk("rst_aborted", 32'(aborted),     32'd0);
    chk("rst_sent",    32'(pulses_sent), 32'd0);
    rst = 1'b0;

    // Basic burst pw=3 gap=2 num=4.
    run_burst(16'd3, 16'd2, 8'd4, 20, '0, '0, 16'd3);
    chk("b1_data", cap_data, pat("11100111001110011100"));
    chk("b1_busy", cap_busy, pat("11111111111111111100"));
    chk("b1_done", cap_done, pat("00000000000000000010"));
    chk("b1_abt",  cap_abt,  pat("00000000000000000000"));
    chk("b1_sent", 32'(pulses_sent), 32'd4);

    // Empty burst.
    run_burst(16'd3, 16'd2, 8'd0, 4, '0, '0, 16'd3);
    chk("e_data", cap_data, pat("0000"));
    chk("e_busy", cap_busy, pat("0000"));
    chk("e_done", cap_done, pat("1000"));
    chk("e_sent", 32'(pulses_sent), 32'd0);

    // Zero widths behave as one.
    run_burst(16'd0, 16'd0, 8'd3, 8, '0, '0, 16'd0);
    chk("z_data", cap_data, pat("10101000"));
    chk("z_done", cap_done, pat("00000100"));
    chk("z_sent", 32'(pulses_sent), 32'd3);

    // Abort during the 2nd cycle of pulse 2 (cycle 10).
    run_burst(16'd4, 16'd4, 8'd5, 12, '0, pat("0000000001"), 16'd4);
    chk("a_data", cap_data, pat("111100001100"));
    chk("a_busy", cap_busy, pat("111111111100"));
    chk("a_done", cap_done, pat("000000000010"));
    chk("a_abt",  cap_abt,  pat("000000000011"));
    chk("a_sent", 32'(pulses_sent), 32'd1);

    // Next start clears aborted and runs normally.
    run_burst(16'd2, 16'd1, 8'd2, 6, '0, '0, 16'd2);
    chk("r_data", cap_data, pat("110110"));
    chk("r_done", cap_done, pat("000001"));
    chk("r_abt",  cap_abt,  pat("000000"));
    chk("r_sent", 32'(pulses_sent), 32'd2);

    // Restart attempts mid-burst and in the done cycle; pulse_width changed to 9.
    run_burst(16'd2, 16'd2, 8'd3, 16, pat("00100100001"), '0, 16'd9);
    chk("s_data", cap_data, pat("1100110011000000"));
    chk("s_busy", cap_busy, pat("1111111111000000"));
    chk("s_done", cap_done, pat("0000000000100000"));
    chk("s_sent", 32'(pulses_sent), 32'd3);

    // Asynchronous reset during pulse 2 of a pw=5 gap=1 num=2 burst.
    run_burst(16'd5, 16'd1, 8'd2, 8, '0, '0, 16'd5);
    chk("x_pre_data", 32'(DATA_OUT),    32'd1);
    chk("x_pre_sent", 32'(pulses_sent), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("x_async_data", 32'(DATA_OUT),    32'd0);
    chk("x_async_busy", 32'(busy),        32'd0);
    chk("x_async_sent", 32'(pulses_sent), 32'd0);
    cap_done = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK_IN);
      cap_done[k] = done;
    end
    rst = 1'b0;
    for (int k = 3; k < 6; k++) begin
      @(negedge CLK_IN);
      cap_done[k] = done;
    end
    chk("x_no_done", cap_done, 32'd0);
    run_burst(16'd1, 16'd1, 8'd1, 3, '0, '0, 16'd1);
    chk("x_data", cap_data, pat("100"));
    chk("x_done", cap_done, pat("010"));
    chk("x_sent", 32'(pulses_sent), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
